// File: rtl/rv32i_types.sv
// Shared fetch-side types: decode handoff record, fetch FSM states and queue entry layout.
package rv32i_types;

   typedef struct packed {
      logic [31:0] fetch_pc_curr;
      logic [31:0] fetch_pc_next;
   } fetch_output_reg_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      FLUSH
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc_curr;
      logic [31:0] pc_next;
      logic [31:0] inst;
   } fetch_queue_entry_t;

   localparam logic [31:0] INST_BYTES = 32'd4;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue; head is read straight from storage, flush clears pointers and count.
// DEPTH must be a power of two so the pointers wrap naturally from DEPTH-1 to 0.
module fetch_queue
   import rv32i_types::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  fetch_queue_entry_t         din,
   output fetch_queue_entry_t         head,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_queue_entry_t mem [DEPTH];
   logic [AW-1:0]      rd_ptr;
   logic [AW-1:0]      wr_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: one outstanding imem request, responses buffered in fetch_queue for decode.
// A redirect flushes the queue; a response already in flight at redirect time is discarded.
module if_stage
   import rv32i_types::*;
#(
   parameter logic [31:0] RESET_PC = 32'h1eceb000,
   parameter int          DEPTH    = 4
) (
   input  logic              clk,
   input  logic              rst,
   output logic [31:0]       imem_addr,
   output logic [3:0]        imem_rmask,
   input  logic [31:0]       imem_rdata,
   input  logic              imem_resp,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   input  logic              stall_inst,
   output logic              inst_valid,
   output logic [31:0]       inst,
   output fetch_output_reg_t fetch_output
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t       state;
   logic [31:0]        fetch_pc;
   logic [31:0]        req_pc;
   logic               push;
   logic               pop;
   logic               space;
   logic [CW-1:0]      count;
   logic [CW-1:0]      count_next;
   fetch_queue_entry_t din;
   fetch_queue_entry_t head;

   assign inst_valid = (count != '0) && !redirect_valid;
   assign pop        = inst_valid && !stall_inst;
   assign push       = (state == BUSY) && imem_resp && !redirect_valid;
   assign count_next = count + CW'(push) - CW'(pop);
   // Issuing only when the post-update count leaves a free slot guarantees the response fits.
   assign space      = count_next < CW'(DEPTH);

   assign din.pc_curr = req_pc;
   assign din.pc_next = req_pc + INST_BYTES;
   assign din.inst    = imem_rdata;

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .din   (din),
      .head  (head),
      .count (count)
   );

   assign imem_addr                  = req_pc;
   assign imem_rmask                 = (state == IDLE) ? 4'h0 : 4'hF;
   assign inst                       = head.inst;
   assign fetch_output.fetch_pc_curr = head.pc_curr;
   assign fetch_output.fetch_pc_next = head.pc_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         req_pc   <= RESET_PC;
      end else begin
         case (state)
            IDLE: begin
               if (redirect_valid) begin
                  state    <= BUSY;
                  req_pc   <= redirect_pc;
                  fetch_pc <= redirect_pc + INST_BYTES;
               end else if (space) begin
                  state    <= BUSY;
                  req_pc   <= fetch_pc;
                  fetch_pc <= fetch_pc + INST_BYTES;
               end
            end
            BUSY: begin
               if (imem_resp && redirect_valid) begin
                  req_pc   <= redirect_pc;
                  fetch_pc <= redirect_pc + INST_BYTES;
               end else if (redirect_valid) begin
                  // Request stays on the bus until memory answers; its data is then dropped.
                  state    <= FLUSH;
                  fetch_pc <= redirect_pc;
               end else if (imem_resp) begin
                  if (space) begin
                     req_pc   <= fetch_pc;
                     fetch_pc <= fetch_pc + INST_BYTES;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            FLUSH: begin
               if (imem_resp) begin
                  state <= BUSY;
                  if (redirect_valid) begin
                     req_pc   <= redirect_pc;
                     fetch_pc <= redirect_pc + INST_BYTES;
                  end else begin
                     req_pc   <= fetch_pc;
                     fetch_pc <= fetch_pc + INST_BYTES;
                  end
               end else if (redirect_valid) begin
                  fetch_pc <= redirect_pc;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, streaming, full-queue stall, redirects and mid-request reset.
module tb_if_stage;
   import rv32i_types::*;

   localparam logic [31:0] B = 32'h1eceb000;

   logic              clk = 1'b0;
   logic              rst;
   logic [31:0]       imem_addr;
   logic [3:0]        imem_rmask;
   logic [31:0]       imem_rdata;
   logic              imem_resp;
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic              stall_inst;
   logic              inst_valid;
   logic [31:0]       inst;
   fetch_output_reg_t fetch_output;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] a;

   if_stage #(
      .RESET_PC (B),
      .DEPTH    (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr),
      .imem_rmask     (imem_rmask),
      .imem_rdata     (imem_rdata),
      .imem_resp      (imem_resp),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall_inst     (stall_inst),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .fetch_output   (fetch_output)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mdat(input logic [31:0] addr);
      return addr ^ 32'h00c0ffee;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench in cycle 0: the first cycle with rst low, FSM still IDLE.
   task automatic reset_dut();
      rst            = 1'b1;
      imem_resp      = 1'b0;
      imem_rdata     = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      stall_inst     = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
      $fatal(1);
   end

   initial begin
      // Reset values, first request and first-response latency.
      reset_dut();
      rst = 1'b1;
      tick();
      check("rst_addr", imem_addr, B);
      check("rst_rmask", imem_rmask, 4'h0);
      check("rst_valid", inst_valid, 1'b0);
      check("rst_inst", inst, 32'h0);
      check("rst_fout", fetch_output, 64'h0);
      rst = 1'b0;
      #1;
      check("c0_rmask", imem_rmask, 4'h0);
      tick();
      check("c1_addr", imem_addr, B);
      check("c1_rmask", imem_rmask, 4'hF);
      tick();
      check("c2_valid", inst_valid, 1'b0);
      imem_resp  = 1'b1;
      imem_rdata = 32'h00000013;
      tick();
      imem_resp = 1'b0;
      check("c3_valid", inst_valid, 1'b1);
      check("c3_inst", inst, 32'h00000013);
      check("c3_fout", fetch_output, {B, B + 32'h4});

      // Back-to-back: memory answers every cycle, decode never stalls.
      for (int k = 0; k < 6; k++) begin
         a = B + 32'h4 + 32'(4 * k);
         check("stream_addr", imem_addr, a);
         check("stream_rmask", imem_rmask, 4'hF);
         if (k > 0) begin
            check("stream_valid", inst_valid, 1'b1);
            check("stream_inst", inst, mdat(a - 32'h4));
            check("stream_fout", fetch_output, {a - 32'h4, a});
         end
         imem_resp  = 1'b1;
         imem_rdata = mdat(a);
         tick();
      end
      imem_resp = 1'b0;

      // Stall fills the queue to DEPTH, FSM idles, release resumes at B+0x10.
      reset_dut();
      stall_inst = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) begin
         a = B + 32'(4 * k);
         check("fill_addr", imem_addr, a);
         check("fill_rmask", imem_rmask, 4'hF);
         imem_resp  = 1'b1;
         imem_rdata = mdat(a);
         tick();
      end
      imem_resp = 1'b0;
      check("full_rmask", imem_rmask, 4'h0);
      check("full_valid", inst_valid, 1'b1);
      check("full_fout", fetch_output, {B, B + 32'h4});
      imem_resp  = 1'b1;
      imem_rdata = 32'hbad0bad0;
      tick();
      imem_resp = 1'b0;
      check("idle_rmask", imem_rmask, 4'h0);
      check("idle_inst", inst, mdat(B));
      stall_inst = 1'b0;
      #1;
      check("release_valid", inst_valid, 1'b1);
      tick();
      check("release_addr", imem_addr, B + 32'h10);
      check("release_rmask", imem_rmask, 4'hF);
      for (int k = 1; k < 4; k++) begin
         a = B + 32'(4 * k);
         check("drain_valid", inst_valid, 1'b1);
         check("drain_fout", fetch_output, {a, a + 32'h4});
         check("drain_inst", inst, mdat(a));
         tick();
      end
      check("drain_empty", inst_valid, 1'b0);
      check("drain_hold_addr", imem_addr, B + 32'h10);

      // Redirect while BUSY without response: request held, its data dropped.
      reset_dut();
      stall_inst = 1'b1;
      tick();
      imem_resp  = 1'b1;
      imem_rdata = mdat(B);
      tick();
      imem_rdata = mdat(B + 32'h4);
      tick();
      imem_resp = 1'b0;
      check("rd_addr", imem_addr, B + 32'h8);
      check("rd_pre_valid", inst_valid, 1'b1);
      redirect_valid = 1'b1;
      redirect_pc    = B + 32'h100;
      #1;
      check("rd_same_valid", inst_valid, 1'b0);
      tick();
      redirect_valid = 1'b0;
      check("rd_hold_valid", inst_valid, 1'b0);
      check("rd_hold_rmask", imem_rmask, 4'hF);
      check("rd_hold_addr", imem_addr, B + 32'h8);
      tick();
      check("rd_hold2_addr", imem_addr, B + 32'h8);
      check("rd_hold2_rmask", imem_rmask, 4'hF);
      imem_resp  = 1'b1;
      imem_rdata = 32'hdeadbeef;
      tick();
      check("rd_new_addr", imem_addr, B + 32'h100);
      check("rd_new_rmask", imem_rmask, 4'hF);
      check("rd_drop_valid", inst_valid, 1'b0);
      stall_inst = 1'b0;
      imem_rdata = mdat(B + 32'h100);
      tick();
      imem_resp = 1'b0;
      check("rd_tgt_valid", inst_valid, 1'b1);
      check("rd_tgt_inst", inst, mdat(B + 32'h100));
      check("rd_tgt_fout", fetch_output, {B + 32'h100, B + 32'h104});
      check("rd_tgt_next", imem_addr, B + 32'h104);

      // Redirect coinciding with a response: immediate reissue at target.
      reset_dut();
      tick();
      imem_resp  = 1'b1;
      imem_rdata = mdat(B);
      tick();
      stall_inst = 1'b1;
      check("rr_pre_valid", inst_valid, 1'b1);
      imem_rdata     = 32'h0badf00d;
      redirect_valid = 1'b1;
      redirect_pc    = B + 32'h200;
      #1;
      check("rr_same_valid", inst_valid, 1'b0);
      tick();
      redirect_valid = 1'b0;
      imem_resp      = 1'b0;
      check("rr_addr", imem_addr, B + 32'h200);
      check("rr_rmask", imem_rmask, 4'hF);
      check("rr_valid", inst_valid, 1'b0);
      imem_resp  = 1'b1;
      imem_rdata = mdat(B + 32'h200);
      tick();
      imem_resp = 1'b0;
      check("rr_tgt_valid", inst_valid, 1'b1);
      check("rr_tgt_fout", fetch_output, {B + 32'h200, B + 32'h204});
      check("rr_tgt_next", imem_addr, B + 32'h204);

      // Reset mid-request with two entries queued.
      reset_dut();
      stall_inst = 1'b1;
      tick();
      imem_resp  = 1'b1;
      imem_rdata = mdat(B);
      tick();
      imem_rdata = mdat(B + 32'h4);
      tick();
      imem_resp = 1'b0;
      check("mr_pre_valid", inst_valid, 1'b1);
      check("mr_pre_addr", imem_addr, B + 32'h8);
      rst = 1'b1;
      tick();
      rst        = 1'b0;
      imem_resp  = 1'b1;
      imem_rdata = 32'hfeedface;
      check("mr_valid", inst_valid, 1'b0);
      check("mr_rmask", imem_rmask, 4'h0);
      check("mr_addr", imem_addr, B);
      tick();
      imem_resp = 1'b0;
      check("mr_restart_addr", imem_addr, B);
      check("mr_restart_rmask", imem_rmask, 4'hF);
      check("mr_stray_valid", inst_valid, 1'b0);
      imem_resp  = 1'b1;
      imem_rdata = mdat(B);
      tick();
      imem_resp = 1'b0;
      check("mr_first_valid", inst_valid, 1'b1);
      check("mr_first_fout", fetch_output, {B, B + 32'h4});
      check("mr_first_inst", inst, mdat(B));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
